pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and taken branches resolved in EX.
- Freezes the pipeline while a multi-cycle data memory access in MEM is outstanding, with a timeout guard.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_mem_wait_timer.sv | 46 ++++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard sequencer.
//   state_e   : sequencer state (S_RUN = 1'b0, S_WAIT = 1'b1)
//   REG_ZERO  : architectural register zero, never a real dependency
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts how long a data memory access has been outstanding and flags the
// cycle on which it must be abandoned.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset (clears the counter)
//   start_i    : access just missed its first cycle, count restarts at 1
//   clear_i    : access finished or was abandoned, count returns to 0
//   advance_i  : still waiting, count increments
//   timeout_o  : counter has reached MEM_TIMEOUT-1 (qualified by the caller)
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic clear_i,
  input  logic advance_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering; the asynchronous
  // reset is in the sensitivity list so it acts without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= CNT_W'(1);
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (advance_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_o = (cnt_q == CNT_LAST);

endmodule : mem_wait_timer

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for a 5-stage pipeline. Freezes the pipe while
// a multi-cycle data memory access is outstanding (with timeout), flushes
// IF/ID and ID/EX on a taken branch resolved in EX, and inserts a one-cycle
// bubble on a load-use dependency. Control outputs are combinational; only
// the FSM state, wait counter and sticky mem_err are registered.
// Ports:
//   clk, reset (async active-low)
//   ID_rs, ID_rt, ID_UseRt            : source operands of the ID instruction
//   EX_MemRead, EX_Write_register     : load destination in EX
//   EX_Branch, EX_Zero                : branch resolution in EX
//   MEM_MemRd, MEM_MemWr, mem_ack     : data memory handshake in MEM
//   PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
//   EX_MEM_Write, MEM_WB_Flush        : pipeline register controls
//   mem_req                           : data memory request
//   mem_err                           : sticky, an access timed out
// Optional: define HAZARD_PERF_CNT_EN to add 32-bit perf_stall / perf_flush
// event counters.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UseRt,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_Write_register,
  input  logic       EX_Branch,
  input  logic       EX_Zero,
  input  logic       MEM_MemRd,
  input  logic       MEM_MemWr,
  input  logic       mem_ack,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Write,
  output logic       ID_EX_Flush,
  output logic       EX_MEM_Write,
  output logic       MEM_WB_Flush,
  output logic       mem_req,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  state_e state_q;
  logic   mem_err_q;

  logic access, in_wait, timer_hit, timed_out;
  logic frozen, br_taken, ld_hazard, ld_use;

  assign access    = MEM_MemRd | MEM_MemWr;
  assign in_wait   = (state_q == S_WAIT);
  assign timed_out = in_wait & ~mem_ack & timer_hit;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  (~in_wait & access & ~mem_ack),
    .clear_i  (in_wait & (mem_ack | timer_hit)),
    .advance_i(in_wait & ~mem_ack & ~timer_hit),
    .timeout_o(timer_hit)
  );

  // Everything is gated by reset so an assertion mid-wait drops mem_req and
  // the freeze immediately, without waiting for the registers to clear.
  assign frozen    = reset & (in_wait ? (~mem_ack & ~timer_hit)
                                      : (access & ~mem_ack));
  assign br_taken  = reset & ~frozen & EX_Branch & EX_Zero;
  assign ld_hazard = EX_MemRead & (EX_Write_register != REG_ZERO) &
                     ((EX_Write_register == ID_rs) |
                      (ID_UseRt & (EX_Write_register == ID_rt)));
  assign ld_use    = reset & ~frozen & ~br_taken & ld_hazard;

  assign mem_req = reset & (in_wait | access);
  assign mem_err = mem_err_q;

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Flush = 1'b0;
    if (frozen) begin
      // Hold everything upstream of MEM; WB sees bubbles until MEM completes.
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (br_taken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (ld_use) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (access && !mem_ack) state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Ack wins over a timeout landing on the same cycle.
          if (mem_ack) begin
            state_q <= S_RUN;
          end else if (timed_out) begin
            state_q   <= S_RUN;
            mem_err_q <= 1'b1;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (frozen || ld_use) perf_stall_q <= perf_stall_q + 32'd1;
      if (br_taken)         perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 16).
// Observed outputs are packed as
//   {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
//    EX_MEM_Write, MEM_WB_Flush, mem_req, mem_err}
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;

  // Frequently used expected patterns.
  localparam logic [8:0] O_NORM   = 9'b110101000;
  localparam logic [8:0] O_LU     = 9'b000111000;
  localparam logic [8:0] O_BR     = 9'b111111000;
  localparam logic [8:0] O_FRZ    = 9'b000000110;
  localparam logic [8:0] O_REQ    = 9'b000000010;
  localparam logic [8:0] O_ERR    = 9'b000000001;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       memread;
    logic [4:0] wreg;
    logic       br;
    logic       zero;
    logic       rd;
    logic       wr;
    logic       ack;
  } in_t;

  typedef struct {
    in_t        i;
    logic [8:0] exp;
    string      name;
  } vec_t;

  logic       clk, reset;
  logic [4:0] ID_rs, ID_rt, EX_Write_register;
  logic       ID_UseRt, EX_MemRead, EX_Branch, EX_Zero;
  logic       MEM_MemRd, MEM_MemWr, mem_ack;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
  logic       EX_MEM_Write, MEM_WB_Flush, mem_req, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: is a request outstanding, and for how many
  // cycles has it already been waiting (1 on the first wait cycle).
  bit m_waiting;
  int m_age;
  bit m_err;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .ID_rs            (ID_rs),
    .ID_rt            (ID_rt),
    .ID_UseRt         (ID_UseRt),
    .EX_MemRead       (EX_MemRead),
    .EX_Write_register(EX_Write_register),
    .EX_Branch        (EX_Branch),
    .EX_Zero          (EX_Zero),
    .MEM_MemRd        (MEM_MemRd),
    .MEM_MemWr        (MEM_MemWr),
    .mem_ack          (mem_ack),
    .PC_Write         (PC_Write),
    .IF_ID_Write      (IF_ID_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Write      (ID_EX_Write),
    .ID_EX_Flush      (ID_EX_Flush),
    .EX_MEM_Write     (EX_MEM_Write),
    .MEM_WB_Flush     (MEM_WB_Flush),
    .mem_req          (mem_req),
    .mem_err          (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall       (perf_stall),
    .perf_flush       (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(int rs, int rt, int use_rt, int memread, int wreg,
                             int br, int zero, int rd, int wr, int ack);
    in_t r;
    r.rs      = rs[4:0];
    r.rt      = rt[4:0];
    r.use_rt  = use_rt[0];
    r.memread = memread[0];
    r.wreg    = wreg[4:0];
    r.br      = br[0];
    r.zero    = zero[0];
    r.rd      = rd[0];
    r.wr      = wr[0];
    r.ack     = ack[0];
    return r;
  endfunction

  function automatic logic [8:0] dut_out();
    return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
            EX_MEM_Write, MEM_WB_Flush, mem_req, mem_err};
  endfunction

  task automatic drive(input in_t v);
    ID_rs             = v.rs;
    ID_rt             = v.rt;
    ID_UseRt          = v.use_rt;
    EX_MemRead        = v.memread;
    EX_Write_register = v.wreg;
    EX_Branch         = v.br;
    EX_Zero           = v.zero;
    MEM_MemRd         = v.rd;
    MEM_MemWr         = v.wr;
    mem_ack           = v.ack;
  endtask

  // One pipeline cycle: drive just after the edge, settle to the falling edge.
  task automatic step(input in_t v);
    @(posedge clk);
    #1 drive(v);
    #4;
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural reference: outputs follow straight from the hazard rules.
  function automatic logic [8:0] model_out(input in_t v);
    bit acc, frz, req, taken, lu;
    acc   = v.rd || v.wr;
    req   = m_waiting || acc;
    if (m_waiting) frz = !v.ack && (m_age < MEM_TIMEOUT - 1);
    else           frz = acc && !v.ack;
    taken = v.br && v.zero;
    lu    = v.memread && (v.wreg != 0) &&
            ((v.wreg == v.rs) || (v.use_rt && v.wreg == v.rt));
    if (frz)        return {7'b0000001, req, m_err};
    else if (taken) return {7'b1111110, req, m_err};
    else if (lu)    return {7'b0001110, req, m_err};
    else            return {7'b1101010, req, m_err};
  endfunction

  task automatic model_tick(input in_t v);
    if (m_waiting) begin
      if (v.ack) begin
        m_waiting = 0;
      end else if (m_age == MEM_TIMEOUT - 1) begin
        m_waiting = 0;
        m_err     = 1;
      end else begin
        m_age++;
      end
    end else if ((v.rd || v.wr) && !v.ack) begin
      m_waiting = 1;
      m_age     = 1;
    end
  endtask

  vec_t vecs[$];
  in_t  idle, rd_wait, rd_ack, wr_wait, v;

  initial begin
    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd_wait = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rd_ack  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    wr_wait = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    //            rs rt ur mr wr br z  rd wr ack
    vecs.push_back('{mk(8, 0, 0, 1, 8, 0, 0, 0, 0, 0), O_LU,   "lu_rs"});
    vecs.push_back('{mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), O_NORM, "lu_r0"});
    vecs.push_back('{mk(1, 9, 1, 1, 9, 0, 0, 0, 0, 0), O_LU,   "lu_rt"});
    vecs.push_back('{mk(1, 9, 0, 1, 9, 0, 0, 0, 0, 0), O_NORM, "rt_unused"});
    vecs.push_back('{mk(8, 0, 0, 0, 8, 0, 0, 0, 0, 0), O_NORM, "no_load"});
    vecs.push_back('{mk(8, 0, 0, 1, 8, 1, 1, 0, 0, 0), O_BR,   "br_over_lu"});
    vecs.push_back('{mk(8, 0, 0, 1, 8, 1, 0, 0, 0, 0), O_LU,   "br_not_taken_lu"});
    vecs.push_back('{mk(3, 4, 1, 0, 5, 1, 0, 0, 0, 0), O_NORM, "br_not_taken"});
    vecs.push_back('{mk(3, 4, 1, 0, 5, 0, 1, 0, 0, 0), O_NORM, "zero_only"});
    vecs.push_back('{mk(3, 4, 1, 0, 5, 1, 1, 0, 0, 0), O_BR,   "br_taken"});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_NORM | O_REQ, "rd_ack_now"});
    vecs.push_back('{mk(7, 0, 0, 1, 7, 0, 0, 0, 1, 1), O_LU | O_REQ,   "wr_ack_lu"});

    // Reset: even with a pending access on the inputs, nothing is requested.
    reset = 1'b0;
    drive(rd_wait);
    #3 check("reset_state", dut_out(), O_NORM);
    @(negedge clk);
    check("reset_hold", dut_out(), O_NORM);
    drive(idle);
    reset = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].i);
      check(vecs[k].name, dut_out(), vecs[k].exp);
    end

    // Read acked on the 3rd cycle: two frozen cycles, req on all three.
    step(rd_wait); check("rd_w1", dut_out(), O_FRZ);
    step(rd_wait); check("rd_w2", dut_out(), O_FRZ);
    step(rd_ack);  check("rd_ack3", dut_out(), O_NORM | O_REQ);
    step(idle);    check("rd_back_run", dut_out(), O_NORM);
    step(rd_ack);  check("rd_run_ack", dut_out(), O_NORM | O_REQ);

    // Freeze masks branch and load-use; they show on the first unfrozen cycle.
    v = mk(8, 0, 0, 1, 8, 1, 1, 1, 0, 0);
    step(v); check("frz_br_1", dut_out(), O_FRZ);
    step(v); check("frz_br_2", dut_out(), O_FRZ);
    v.ack = 1'b1;
    step(v); check("frz_br_release", dut_out(), O_BR | O_REQ);
    v.br = 1'b0;
    v.rd = 1'b0;
    step(v); check("lu_after_frz", dut_out(), O_LU);

    // Ack arriving on the timeout cycle wins: no error.
    for (int i = 1; i < MEM_TIMEOUT; i++) begin
      step(rd_wait); check($sformatf("ackedge_w%0d", i), dut_out(), O_FRZ);
    end
    step(rd_ack); check("ackedge_ack", dut_out(), O_NORM | O_REQ);
    step(idle);   check("ackedge_no_err", dut_out(), O_NORM);

    // Write never acked: 15 frozen cycles, release on the 16th, sticky error.
    for (int i = 1; i < MEM_TIMEOUT; i++) begin
      step(wr_wait); check($sformatf("to_w%0d", i), dut_out(), O_FRZ);
    end
    step(wr_wait); check("to_release", dut_out(), O_NORM | O_REQ);
    step(idle);    check("to_err_set", dut_out(), O_NORM | O_ERR);
    step(rd_ack);  check("to_err_sticky1", dut_out(), O_NORM | O_REQ | O_ERR);
    step(idle);    check("to_err_sticky2", dut_out(), O_NORM | O_ERR);

    // Reset on the 4th wait cycle drops mem_req at once and clears mem_err.
    step(wr_wait); check("rst_w1", dut_out(), O_FRZ | O_ERR);
    step(wr_wait); check("rst_w2", dut_out(), O_FRZ | O_ERR);
    step(wr_wait); check("rst_w3", dut_out(), O_FRZ | O_ERR);
    @(posedge clk);
    #1 drive(wr_wait);
    #1 reset = 1'b0;
    #1 check("rst_mid_wait", dut_out(), O_NORM);
    @(negedge clk);
    drive(idle);
    reset = 1'b1;
    step(idle);   check("rst_released", dut_out(), O_NORM);
    step(rd_ack); check("rst_run_state", dut_out(), O_NORM | O_REQ);

    // Randomized traffic against the reference model.
    m_waiting = 0;
    m_age     = 0;
    m_err     = 0;
    for (int n = 0; n < 600; n++) begin
      int acc_sel;
      acc_sel = int'($urandom_range(0, 9));
      v = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)),
             (acc_sel < 2) ? 1 : 0, (acc_sel == 2) ? 1 : 0,
             ($urandom_range(0, 9) < 2) ? 1 : 0);
      step(v);
      check($sformatf("rand_%0d", n), dut_out(), model_out(v));
      model_tick(v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
